// File: rtl/clk_rst_pkg.sv
// Shared types and widths for the PLL clock/reset sequencer.
package clk_rst_pkg;

    localparam int CNT_W   = 16;
    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        PLLRST = 3'd0,
        WAIT   = 3'd1,
        HOLD   = 3'd2,
        RUN    = 3'd3,
        STBY   = 3'd4
    } state_e;

    // Saturating increment; the retry count sticks at all-ones instead of wrapping.
    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (&v) ? v : v + RETRY_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// PLL reset/lock sequencer producing the downstream system reset.
// Build option SIM_LOCK_BYPASS_EN forces lock_s high and ignores extlock.
//
// state  | meaning
// PLLRST | PLL held in reset for PLL_RST_CYC cycles
// WAIT   | waiting for lock, retry after TIMEOUT_CYC cycles
// HOLD   | counting HOLD_CYC consecutive locked cycles
// RUN    | locked, system reset released
// STBY   | PLL in standby, system held in reset
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int PLL_RST_CYC = 16,
    parameter int TIMEOUT_CYC = 50000,
    parameter int HOLD_CYC    = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               extlock,
    input  logic               stdby_req,
    input  logic               lost_clr,
    output logic               pll_reset,
    output logic               pll_stdby,
    output logic               sys_rst_n,
    output logic               locked,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [CNT_W-1:0] PLL_RST_TC = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(HOLD_CYC - 1);

    logic lock_s;

`ifdef SIM_LOCK_BYPASS_EN
    logic unused_extlock;
    assign unused_extlock = extlock;
    assign lock_s         = 1'b1;
`else
    sync_2ff u_lock_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (extlock),
        .q_o   (lock_s)
    );
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_reset_q, pll_reset_d;
    logic               pll_stdby_q, pll_stdby_d;
    logic               run_q, run_d;
    logic               lost_q, lost_d;
    logic               loss;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        loss    = 1'b0;

        case (state_q)
            PLLRST: begin
                if (cnt_q == PLL_RST_TC) state_d = WAIT;
            end
            WAIT: begin
                if (lock_s) begin
                    state_d = HOLD;
                end else if (cnt_q == TIMEOUT_TC) begin
                    state_d = PLLRST;
                    retry_d = sat_inc(retry_q);
                end
            end
            HOLD: begin
                if (!lock_s)               state_d = WAIT;
                else if (cnt_q == HOLD_TC) state_d = RUN;
            end
            RUN: begin
                // Lock loss outranks a simultaneous standby request.
                if (!lock_s) begin
                    state_d = PLLRST;
                    loss    = 1'b1;
                end else if (stdby_req) begin
                    state_d = STBY;
                end
                cnt_d = '0;
            end
            STBY: begin
                if (!stdby_req) state_d = PLLRST;
                cnt_d = '0;
            end
            default: begin
                state_d = PLLRST;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Outputs are decoded from the next state so they change on the transition edge.
        pll_reset_d = (state_d == PLLRST);
        pll_stdby_d = (state_d == STBY);
        run_d       = (state_d == RUN);
        lost_d      = loss | (lost_q & ~lost_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PLLRST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            pll_stdby_q <= 1'b0;
            run_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            pll_stdby_q <= pll_stdby_d;
            run_q       <= run_d;
            lost_q      <= lost_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign pll_stdby = pll_stdby_q;
    assign sys_rst_n = run_q;
    assign locked    = run_q;
    assign lock_lost = lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with PLL_RST_CYC=4, TIMEOUT_CYC=100, HOLD_CYC=8.
module tb_clk_rst_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       extlock;
    logic       stdby_req;
    logic       lost_clr;
    logic       pll_reset;
    logic       pll_stdby;
    logic       sys_rst_n;
    logic       locked;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int bad    = 0;

    always #5 clk = ~clk;

    clk_rst_seq #(
        .PLL_RST_CYC (4),
        .TIMEOUT_CYC (100),
        .HOLD_CYC    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .extlock   (extlock),
        .stdby_req (stdby_req),
        .lost_clr  (lost_clr),
        .pll_reset (pll_reset),
        .pll_stdby (pll_stdby),
        .sys_rst_n (sys_rst_n),
        .locked    (locked),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt)
    );

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_vec({tag, ".pll_reset"}, 32'(pll_reset), 32'd1);
        chk_vec({tag, ".pll_stdby"}, 32'(pll_stdby), 32'd0);
        chk_vec({tag, ".sys_rst_n"}, 32'(sys_rst_n), 32'd0);
        chk_vec({tag, ".locked"},    32'(locked),    32'd0);
        chk_vec({tag, ".lock_lost"}, 32'(lock_lost), 32'd0);
        chk_vec({tag, ".retry_cnt"}, 32'(retry_cnt), 32'd0);
    endtask

    initial begin
        // Power-up with lock present from the start
        rst = 1'b1; extlock = 1'b1; stdby_req = 1'b0; lost_clr = 1'b0;
        step(3);
        chk_reset_vals("rst_init");
        rst = 1'b0;
        step(3);  chk_vec("boot_pllrst_d3", 32'(pll_reset), 32'd1);
        step(1);  chk_vec("boot_pllrst_d4", 32'(pll_reset), 32'd0);
        step(8);  chk_vec("boot_rel_d12",   32'(sys_rst_n), 32'd0);
        step(1);  chk_vec("boot_rel_d13",   32'(sys_rst_n), 32'd1);
                  chk_vec("boot_locked",    32'(locked),    32'd1);
                  chk_vec("boot_retry",     32'(retry_cnt), 32'd0);

        // Lock loss in RUN
        extlock = 1'b0; step(1);
        extlock = 1'b1; step(1);
        chk_vec("loss_l1_run",    32'(sys_rst_n), 32'd1);
        step(1);
        chk_vec("loss_l2_rstn",   32'(sys_rst_n), 32'd0);
        chk_vec("loss_l2_locked", 32'(locked),    32'd0);
        chk_vec("loss_l2_lost",   32'(lock_lost), 32'd1);
        chk_vec("loss_l2_pllrst", 32'(pll_reset), 32'd1);
        step(3);  chk_vec("loss_pllrst_l5", 32'(pll_reset), 32'd1);
        step(1);  chk_vec("loss_pllrst_l6", 32'(pll_reset), 32'd0);
                  chk_vec("loss_sticky",    32'(lock_lost), 32'd1);
        lost_clr = 1'b1; step(1); lost_clr = 1'b0;
        chk_vec("lost_clr", 32'(lock_lost), 32'd0);
        step(7);  chk_vec("loss_rel_l14", 32'(sys_rst_n), 32'd0);
        step(1);  chk_vec("loss_rel_l15", 32'(sys_rst_n), 32'd1);

        // lost_clr coincident with a loss event: set wins
        extlock = 1'b0; step(1);
        extlock = 1'b1; step(1);
        lost_clr = 1'b1; step(1); lost_clr = 1'b0;
        chk_vec("setwin_lost", 32'(lock_lost), 32'd1);
        chk_vec("setwin_rstn", 32'(sys_rst_n), 32'd0);
        step(12); chk_vec("setwin_rel_m14", 32'(sys_rst_n), 32'd0);
        step(1);  chk_vec("setwin_rel_m15", 32'(sys_rst_n), 32'd1);
        lost_clr = 1'b1; step(1); lost_clr = 1'b0;
        chk_vec("setwin_clr", 32'(lock_lost), 32'd0);

        // One-cycle glitch after 5 cycles in HOLD
        extlock = 1'b0; step(3);
        chk_vec("glitch_lossrst", 32'(sys_rst_n), 32'd0);
        step(6);
        chk_vec("glitch_in_wait", 32'(pll_reset), 32'd0);
        extlock = 1'b1; step(1);
        step(5);
        extlock = 1'b0; step(1);
        extlock = 1'b1; step(1);
        step(3);  chk_vec("glitch_no_early", 32'(sys_rst_n), 32'd0);
        step(6);  chk_vec("glitch_rel_9",    32'(sys_rst_n), 32'd0);
        step(1);  chk_vec("glitch_rel_10",   32'(sys_rst_n), 32'd1);
                  chk_vec("glitch_retry",    32'(retry_cnt), 32'd0);
        lost_clr = 1'b1; step(1); lost_clr = 1'b0;

        // Standby with lock dropping inside STBY
        stdby_req = 1'b1; step(1);
        chk_vec("stby_s0_stdby",  32'(pll_stdby), 32'd1);
        chk_vec("stby_s0_rstn",   32'(sys_rst_n), 32'd0);
        chk_vec("stby_s0_locked", 32'(locked),    32'd0);
        chk_vec("stby_s0_pllrst", 32'(pll_reset), 32'd0);
        extlock = 1'b0;
        step(10);
        chk_vec("stby_s10_stdby", 32'(pll_stdby), 32'd1);
        chk_vec("stby_s10_lost",  32'(lock_lost), 32'd0);
        step(9);
        stdby_req = 1'b0; extlock = 1'b1;
        step(1);
        chk_vec("stby_exit_stdby",  32'(pll_stdby), 32'd0);
        chk_vec("stby_exit_pllrst", 32'(pll_reset), 32'd1);
        step(3);  chk_vec("stby_pllrst_s23", 32'(pll_reset), 32'd1);
        step(1);  chk_vec("stby_pllrst_s24", 32'(pll_reset), 32'd0);
        step(8);  chk_vec("stby_rel_s32",    32'(sys_rst_n), 32'd0);
        step(1);  chk_vec("stby_rel_s33",    32'(sys_rst_n), 32'd1);
                  chk_vec("stby_rel_lost",   32'(lock_lost), 32'd0);

        // Loss and stdby_req on the same RUN cycle: loss wins
        extlock = 1'b0; step(2);
        stdby_req = 1'b1; step(1);
        chk_vec("prio_stdby",  32'(pll_stdby), 32'd0);
        chk_vec("prio_lost",   32'(lock_lost), 32'd1);
        chk_vec("prio_pllrst", 32'(pll_reset), 32'd1);
        chk_vec("prio_rstn",   32'(sys_rst_n), 32'd0);
        stdby_req = 1'b0; extlock = 1'b1;
        step(13);
        chk_vec("prio_rel",    32'(sys_rst_n), 32'd1);
        chk_vec("prio_sticky", 32'(lock_lost), 32'd1);

        // rst in RUN returns everything to reset values, lock_lost included
        rst = 1'b1; step(1);
        chk_reset_vals("rst_run");

        // No lock for 1700 cycles; stdby_req asserted outside RUN must be ignored
        extlock = 1'b0; stdby_req = 1'b1;
        step(2);
        rst = 1'b0;
        for (int c = 1; c <= 1700; c++) begin
            step(1);
            if (c == 300) stdby_req = 1'b0;
            if (sys_rst_n !== 1'b0 || pll_stdby !== 1'b0) bad++;
            if (c == 103) begin
                chk_vec("to_retry_d103",  32'(retry_cnt), 32'd0);
                chk_vec("to_pllrst_d103", 32'(pll_reset), 32'd0);
            end
            if (c == 104) begin
                chk_vec("to_retry_d104",  32'(retry_cnt), 32'd1);
                chk_vec("to_pllrst_d104", 32'(pll_reset), 32'd1);
            end
            if (c == 1559) chk_vec("to_retry_d1559", 32'(retry_cnt), 32'd14);
            if (c == 1560) chk_vec("to_retry_d1560", 32'(retry_cnt), 32'd15);
            if (c == 1664) chk_vec("to_retry_d1664", 32'(retry_cnt), 32'd15);
        end
        chk_vec("to_retry_sat",   32'(retry_cnt), 32'd15);
        chk_vec("to_no_release",  32'(bad),       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/clk_rst_seq.md
CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 Parameter PLL_RST_CYC, default 16, cycles pll_reset is held per attempt (1..65535).
REQ-002 Parameter TIMEOUT_CYC, default 50000, cycles to wait for lock before retrying (1..65535).
REQ-003 Parameter HOLD_CYC, default 256, consecutive locked cycles required before releasing system reset (1..65535).
REQ-004 clk  in  1  single block clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 extlock  in  1  PLL lock indication, asynchronous to clk.
REQ-007 stdby_req  in  1  request to put the PLL in standby (clk domain).
REQ-008 lost_clr  in  1  one-cycle pulse clearing lock_lost.
REQ-009 pll_reset  out  1  drives the PLL reset input.
REQ-010 pll_stdby  out  1  drives the PLL stdby input.
REQ-011 sys_rst_n  out  1  active-low reset for downstream UART logic.
REQ-012 locked  out  1  high only in RUN.
REQ-013 lock_lost  out  1  sticky flag: lock dropped while in RUN.
REQ-014 retry_cnt  out  4  count of lock timeouts, saturating at 15.

Function
REQ-015 extlock SHALL pass through a 2-flop synchronizer; the output is lock_s. All decisions use lock_s only.
REQ-016 FSM states SHALL be PLLRST, WAIT, HOLD, RUN and STBY. All outputs SHALL be registered.
REQ-017 PLLRST: pll_reset=1 and sys_rst_n=0; after exactly PLL_RST_CYC cycles, go to WAIT with pll_reset=0.
REQ-018 WAIT: lock_s=1 -> HOLD with the counter cleared; TIMEOUT_CYC cycles without lock -> PLLRST and retry_cnt+1 (saturates at 15, no wrap).
REQ-019 HOLD: lock_s=0 on any cycle -> WAIT with the counter cleared; HOLD_CYC consecutive lock_s=1 cycles -> RUN.
REQ-020 Release latency: sys_rst_n and locked SHALL rise on the clock edge exactly HOLD_CYC+2 edges after the edge that first samples extlock=1 in WAIT.
REQ-021 RUN: lock_s=0 -> PLLRST; on that same edge sys_rst_n=0, locked=0, lock_lost=1. Assertion latency is 2 edges after the edge that samples extlock=0.
REQ-022 RUN with stdby_req=1 -> STBY: pll_stdby=1, sys_rst_n=0, locked=0. A lock drop while in STBY SHALL NOT set lock_lost. stdby_req=0 -> PLLRST.
REQ-023 If stdby_req and lock loss occur on the same RUN cycle, loss SHALL take priority: go to PLLRST and set lock_lost.
REQ-024 If lost_clr and a loss event coincide, lock_lost SHALL end the cycle set (set wins).
REQ-025 stdby_req SHALL be ignored in every state except RUN.
REQ-026 All counters SHALL be 16 bits and cleared on every state entry.

Reset
REQ-027 rst=1 SHALL override all other inputs. On the next edge: state=PLLRST, counters=0, pll_reset=1, pll_stdby=0, sys_rst_n=0, locked=0, lock_lost=0, retry_cnt=0, synchronizer flops=0.
REQ-028 rst asserted mid-operation, including in RUN, SHALL restart the full sequence and SHALL NOT set lock_lost.

Configuration
REQ-029 Macro SIM_LOCK_BYPASS_EN. When defined, lock_s SHALL be constant 1 and extlock SHALL be ignored, for simulation with the PLL model that ties lock low. Sequence timing is otherwise unchanged: release occurs PLL_RST_CYC+1+HOLD_CYC edges after rst deasserts. When undefined, REQ-015 applies.

Structure
REQ-030 Package clk_rst_pkg SHALL hold the state enumeration, CNT_W=16 and RETRY_W=4.
REQ-031 Sub-module sync_2ff SHALL implement the extlock synchronizer.

Verification (PLL_RST_CYC=4, TIMEOUT_CYC=100, HOLD_CYC=8, bypass undefined)
REQ-032 rst for 3 cycles, extlock high from the start -> pll_reset high for 4 cycles, then sys_rst_n=1 and locked=1; retry_cnt=0.
REQ-033 extlock held low for 1700 cycles -> 16+ timeouts; retry_cnt stops at 15; sys_rst_n stays 0.
REQ-034 extlock glitches low for 1 cycle after 5 cycles in HOLD -> HOLD restarts; sys_rst_n rises 10 edges after the glitch ends.
REQ-035 In RUN, drop extlock -> sys_rst_n low 2 edges later, lock_lost=1, pll_reset high 4 cycles; lost_clr pulse then clears lock_lost.
REQ-036 In RUN, stdby_req=1 for 20 cycles with extlock dropping -> pll_stdby=1 and lock_lost=0; on release, the full sequence repeats.
REQ-037 rst asserted in RUN -> all outputs return to their reset values on the next edge.
